// File: rtl/ext_intr_ctrl.sv
// External interrupt controller: synchronises up to 32 sources, qualifies them
// as level or rising-edge, latches and masks them, and drives a slice of the
// external interrupt vector. Configured through a register-interface slave.

package reg_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module ext_intr_ctrl #(
    parameter int unsigned NSRC        = 4,
    parameter int unsigned NOUT        = 64,
    parameter int unsigned BASE_IDX    = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NSRC-1:0]     src_i,
    input  reg_pkg::reg_req_t   reg_req_i,
    output reg_pkg::reg_rsp_t   reg_rsp_o,
    output logic [NOUT-1:0]     intr_o
);

    if (NSRC < 1 || NSRC > 32) begin : g_bad_nsrc
        $error("ext_intr_ctrl: NSRC must be 1..32");
    end
    if (BASE_IDX + NSRC > NOUT) begin : g_bad_base
        $error("ext_intr_ctrl: BASE_IDX+NSRC exceeds NOUT");
    end
    if (SYNC_STAGES > 3) begin : g_bad_sync
        $error("ext_intr_ctrl: SYNC_STAGES must be 0..3");
    end

    logic [NSRC-1:0] sync;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign sync = src_i;
    end else begin : g_sync
        logic [NSRC-1:0] stage_q [SYNC_STAGES];

        // Plain flop chain per source; the last stage is the synchronised value.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int s = 0; s < int'(SYNC_STAGES); s++) stage_q[s] <= '0;
            end else begin
                stage_q[0] <= src_i;
                for (int s = 1; s < int'(SYNC_STAGES); s++) stage_q[s] <= stage_q[s-1];
            end
        end

        assign sync = stage_q[SYNC_STAGES-1];
    end

    // Offsets: 0 ENABLE, 1 MODE, 2 PENDING, 3 RAW, 4 OVERFLOW, 5..7 unmapped.
    logic [2:0]      idx;
    logic            wr;
    logic [NSRC-1:0] wdata;
    logic            unused_bits;

    assign idx         = reg_req_i.addr[4:2];
    assign wr          = reg_req_i.valid & reg_req_i.write;
    assign wdata       = reg_req_i.wdata[NSRC-1:0];
    assign unused_bits = ^{reg_req_i.wstrb, reg_req_i.addr[31:5], reg_req_i.addr[1:0],
                           reg_req_i.wdata};

    logic [NSRC-1:0] enable_q, enable_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] ovf_q, ovf_d;
    logic [NSRC-1:0] prev_q;
    logic [NSRC-1:0] edge_det, pend_clr, ovf_clr, mode_chg, ovf_set;

    // Next-state: edge sets beat W1C, and a mode change wipes the affected bits.
    always_comb begin
        edge_det  = sync & ~prev_q;
        pend_clr  = (wr && idx == 3'd2) ? wdata : '0;
        ovf_clr   = (wr && idx == 3'd4) ? wdata : '0;
        mode_chg  = (wr && idx == 3'd1) ? (wdata ^ mode_q) : '0;
        enable_d  = (wr && idx == 3'd0) ? wdata : enable_q;
        mode_d    = (wr && idx == 3'd1) ? wdata : mode_q;
        ovf_set   = mode_q & edge_det & pending_q & ~pend_clr;
        pending_d = (mode_q & ((pending_q & ~pend_clr) | edge_det)) | (~mode_q & sync);
        pending_d = pending_d & ~mode_chg;
        ovf_d     = ((ovf_q & ~ovf_clr) | ovf_set) & ~mode_chg;
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            enable_q  <= '0;
            mode_q    <= '0;
            pending_q <= '0;
            ovf_q     <= '0;
            prev_q    <= '0;
        end else begin
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            prev_q    <= sync;
        end
    end

    // Combinational read response; pure address decode, always ready.
    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.ready = 1'b1;
        unique case (idx)
            3'd0:    reg_rsp_o.rdata[NSRC-1:0] = enable_q;
            3'd1:    reg_rsp_o.rdata[NSRC-1:0] = mode_q;
            3'd2:    reg_rsp_o.rdata[NSRC-1:0] = pending_q;
            3'd3:    reg_rsp_o.rdata[NSRC-1:0] = sync;
            3'd4:    reg_rsp_o.rdata[NSRC-1:0] = ovf_q;
            default: reg_rsp_o.error = 1'b1;
        endcase
    end

    // Interrupt lines come straight from flops through a single AND.
    always_comb begin
        intr_o                      = '0;
        intr_o[BASE_IDX +: NSRC]    = pending_q & enable_q;
    end

endmodule

// File: tb/tb_ext_intr_ctrl.sv
// Directed bench for ext_intr_ctrl with default parameters
// (NSRC=4, NOUT=64, BASE_IDX=2, SYNC_STAGES=2).
module tb_ext_intr_ctrl;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [3:0]        src_i;
    reg_pkg::reg_req_t reg_req_i;
    reg_pkg::reg_rsp_t reg_rsp_o;
    logic [63:0]       intr_o;

    int errs   = 0;
    int checks = 0;

    localparam logic [31:0] A_EN = 32'h00, A_MODE = 32'h04, A_PEND = 32'h08,
                            A_RAW = 32'h0C, A_OVF = 32'h10;

    ext_intr_ctrl dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .src_i     (src_i),
        .reg_req_i (reg_req_i),
        .reg_rsp_o (reg_rsp_o),
        .intr_o    (intr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic reg_rd(input logic [31:0] a, output logic [31:0] d, output logic e);
        reg_req_i.valid = 1'b1;
        reg_req_i.write = 1'b0;
        reg_req_i.addr  = a;
        #1;
        d = reg_rsp_o.rdata;
        e = reg_rsp_o.error;
        reg_req_i.valid = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        reg_rd(a, d, e);
        chk(tag, d, exp);
    endtask

    task automatic reg_wr(input logic [31:0] a, input logic [31:0] d);
        reg_req_i.valid = 1'b1;
        reg_req_i.write = 1'b1;
        reg_req_i.addr  = a;
        reg_req_i.wdata = d;
        step();
        reg_req_i.valid = 1'b0;
        reg_req_i.write = 1'b0;
    endtask

    // One-cycle pulse; after return the pulse has reached PENDING.
    task automatic pulse(input int b);
        src_i[b] = 1'b1;
        step();
        src_i[b] = 1'b0;
        step();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        logic [31:0] addrs [5];
        addrs = '{A_EN, A_MODE, A_PEND, A_RAW, A_OVF};

        rst_ni    = 1'b0;
        src_i     = '0;
        reg_req_i = '0;
        #1;
        chk("ready_in_reset", {63'd0, reg_rsp_o.ready}, 64'd1);
        chk("intr_in_reset", intr_o, 64'd0);
        step();
        step();
        rst_ni = 1'b1;
        step();

        // Reset values of all mapped registers
        for (int i = 0; i < 5; i++) begin
            reg_rd(addrs[i], d, e);
            chk($sformatf("rst_rdata_%0h", addrs[i]), d, 32'd0);
            chk($sformatf("rst_err_%0h", addrs[i]), e, 1'b0);
        end
        step();
        reg_rd(32'h14, d, e);
        chk("unmapped_14_err", e, 1'b1);
        chk("unmapped_14_rdata", d, 32'd0);
        reg_rd(32'h1C, d, e);
        chk("unmapped_1c_err", e, 1'b1);
        chk("intr_after_rst", intr_o, 64'd0);

        // Level path
        reg_wr(A_EN, 32'h1);
        chk_rd("enable_rb", A_EN, 32'h1);
        src_i[0] = 1'b1;
        step();
        step();
        chk("lvl_intr_k1", intr_o, 64'd0);
        chk_rd("lvl_pend_k1", A_PEND, 32'h0);
        chk_rd("lvl_raw_k1", A_RAW, 32'h1);
        step();
        chk("lvl_intr_k2", intr_o, 64'h4);
        chk_rd("lvl_pend_k2", A_PEND, 32'h1);
        reg_wr(A_PEND, 32'h1);
        chk_rd("lvl_w1c_noeffect", A_PEND, 32'h1);
        src_i[0] = 1'b0;
        step();
        step();
        chk("lvl_drop_k1", intr_o, 64'h4);
        step();
        chk("lvl_drop_k2", intr_o, 64'd0);

        // Edge mode and W1C
        reg_wr(A_MODE, 32'h2);
        reg_wr(A_EN, 32'h2);
        pulse(1);
        chk_rd("edge_pend", A_PEND, 32'h2);
        chk("edge_intr", intr_o, 64'h8);
        repeat (3) step();
        chk("edge_intr_held", intr_o, 64'h8);
        reg_wr(A_PEND, 32'h2);
        chk("edge_w1c_intr", intr_o, 64'd0);
        chk_rd("edge_w1c_pend", A_PEND, 32'h0);

        // Overflow and set-vs-clear simultaneity
        pulse(1);
        chk_rd("ovf_first_pend", A_PEND, 32'h2);
        chk_rd("ovf_first_ovf", A_OVF, 32'h0);
        pulse(1);
        chk_rd("ovf_second", A_OVF, 32'h2);
        reg_wr(A_OVF, 32'h2);
        chk_rd("ovf_w1c", A_OVF, 32'h0);
        src_i[1] = 1'b1;
        step();
        src_i[1] = 1'b0;
        step();
        reg_wr(A_PEND, 32'h2);
        chk_rd("simul_pend", A_PEND, 32'h2);
        chk_rd("simul_ovf", A_OVF, 32'h0);

        // Masked latch, late enable, mode toggle
        reg_wr(A_EN, 32'h0);
        reg_wr(A_MODE, 32'h6);
        pulse(2);
        chk_rd("mask_pend", A_PEND, 32'h6);
        chk("mask_intr", intr_o, 64'd0);
        reg_wr(A_EN, 32'h4);
        chk("late_en_intr", intr_o, 64'h10);
        reg_wr(A_MODE, 32'h2);
        chk_rd("mode_tog_pend", A_PEND, 32'h2);
        chk("mode_tog_intr", intr_o, 64'd0);

        // Reset mid-operation
        reg_wr(A_MODE, 32'h0);
        src_i = 4'hF;
        step();
        step();
        step();
        reg_wr(A_EN, 32'hF);
        chk_rd("pre_rst_pend", A_PEND, 32'hF);
        chk("pre_rst_intr", intr_o, 64'h3C);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_intr", intr_o, 64'd0);
        src_i = '0;
        step();
        rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk_rd($sformatf("post_rst_%0h", addrs[i]), addrs[i], 32'd0);
        end
        chk("post_rst_intr", intr_o, 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
